vram_writer: RTL and testbench

VRAM_WRITER -- requirements
Module: vram_writer

---
 rtl/vram_writer_if.sv | 11 +
 rtl/vram_writer.sv | 171 +++++++++++++++++
 tb/tb_vram_writer.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_writer_if.sv
// Host register bus of vram_writer: one access per clk while cs is high, with registered read data.
interface vram_writer_if;
  logic       cs;
  logic       we;
  logic [2:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;

  modport master (output cs, output we, output addr, output wdata, input rdata);
  modport slave  (input cs, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/vram_writer.sv
// Host register file feeding the screen, colour and font VRAM write ports plus display config.
// Define VRAM_WRITER_FILL_EN to build the block-fill engine (CTRL[7]); without it busy is tied 0.
module vram_writer (
  input  logic         clk,
  input  logic         reset,
  vram_writer_if.slave host,
  output logic         busy,
  output logic [12:0]  saddr,
  output logic [7:0]   swdata,
  output logic         swe,
  output logic [10:0]  caddr,
  output logic [7:0]   cwdata,
  output logic         cwe,
  output logic [11:0]  faddr,
  output logic [7:0]   fwdata,
  output logic         fwe,
  output logic         mode,
  output logic         blink_on,
  output logic         cursor_on,
  output logic [3:0]   hshift,
  output logic [6:0]   cursor_x,
  output logic [4:0]   cursor_y,
  output logic [7:0]   cursor_ch,
  output logic [7:0]   first_row
);

  logic [12:0] ptr_r;
  logic [1:0]  target_r;
  logic [7:0]  fill_val_r;

  logic        host_wr_s;
  logic        host_rd_s;
  logic        data_wr_s;
  logic        fill_wr_s;
  logic        vram_wr_s;
  logic [7:0]  vram_data_s;
  logic        at_last_s;
  logic [12:0] ptr_next_s;

  assign host_wr_s   = host.cs & host.we;
  assign host_rd_s   = host.cs & ~host.we;
  assign data_wr_s   = host_wr_s & (host.addr == 3'd3) & ~busy;
  assign vram_wr_s   = data_wr_s | fill_wr_s;
  assign vram_data_s = fill_wr_s ? fill_val_r : host.wdata;

  // Pointer advance: wrap to 0 at the selected target's last address
  always_comb begin
    at_last_s  = 1'b0;
    ptr_next_s = ptr_r + 13'h0001;
    case (target_r)
      2'b00:   at_last_s = (ptr_r == 13'h1FFF);
      2'b01:   at_last_s = (ptr_r[10:0] == 11'h7FF);
      2'b10:   at_last_s = (ptr_r[11:0] == 12'hFFF);
      default: at_last_s = (ptr_r == 13'h1FFF);
    endcase
    if (at_last_s) begin
      ptr_next_s = 13'h0000;
    end else begin
      ptr_next_s = ptr_r + 13'h0001;
    end
  end

`ifdef VRAM_WRITER_FILL_EN
  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} fill_state_t;
  fill_state_t state_r;
  fill_state_t state_next_s;
  logic        start_s;

  assign start_s = host_wr_s & (host.addr == 3'd0) & host.wdata[7] & ~busy;

  // Fill engine state register
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_next_s;
  end

  // Fill engine next state and per-cycle write request; target 11 just spends one cycle in FILL
  always_comb begin
    state_next_s = state_r;
    fill_wr_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_s) state_next_s = FILL;
        else         state_next_s = IDLE;
      end
      FILL: begin
        if (target_r != 2'b11) fill_wr_s = 1'b1;
        else                   fill_wr_s = 1'b0;
        if (at_last_s || (target_r == 2'b11)) state_next_s = IDLE;
        else                                  state_next_s = FILL;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // busy covers the cycle after the start write through the cycle showing the last strobe
  always_ff @(posedge clk) begin
    if (reset) busy <= 1'b0;
    else       busy <= (state_next_s == FILL) || (state_r == FILL);
  end
`else
  assign fill_wr_s = 1'b0;
  assign busy      = 1'b0;
`endif

  // Host register writes and VRAM write strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r <= 13'h0000;  target_r <= 2'b00;  fill_val_r <= 8'h00;
      mode <= 1'b0;  blink_on <= 1'b0;  cursor_on <= 1'b0;  hshift <= 4'h0;
      cursor_x <= 7'h00;  cursor_y <= 5'h00;  cursor_ch <= 8'h00;  first_row <= 8'h00;
      saddr <= 13'h0000;  swdata <= 8'h00;  swe <= 1'b0;
      caddr <= 11'h000;   cwdata <= 8'h00;  cwe <= 1'b0;
      faddr <= 12'h000;   fwdata <= 8'h00;  fwe <= 1'b0;
    end else begin
      swe <= 1'b0;
      cwe <= 1'b0;
      fwe <= 1'b0;
      if (host_wr_s) begin
        case (host.addr)
          3'd0: begin
            hshift    <= host.wdata[6:3];
            cursor_on <= host.wdata[2];
            blink_on  <= host.wdata[1];
            mode      <= host.wdata[0];
          end
          3'd1: if (!busy) ptr_r[7:0] <= host.wdata;
          3'd2: if (!busy) begin
            target_r    <= host.wdata[7:6];
            ptr_r[12:8] <= host.wdata[4:0];
          end
          3'd3: if (!busy) fill_val_r <= host.wdata;
          3'd4: cursor_x  <= host.wdata[6:0];
          3'd5: cursor_y  <= host.wdata[4:0];
          3'd6: cursor_ch <= host.wdata;
          3'd7: first_row <= host.wdata;
          default: ;
        endcase
      end
      if (vram_wr_s) begin
        ptr_r <= ptr_next_s;
        case (target_r)
          2'b00: begin saddr <= ptr_r;        swdata <= vram_data_s; swe <= 1'b1; end
          2'b01: begin caddr <= ptr_r[10:0]; cwdata <= vram_data_s; cwe <= 1'b1; end
          2'b10: begin faddr <= ptr_r[11:0]; fwdata <= vram_data_s; fwe <= 1'b1; end
          default: ;
        endcase
      end
    end
  end

  // Registered read-back; unused bits read 0
  always_ff @(posedge clk) begin
    if (reset) begin
      host.rdata <= 8'h00;
    end else if (host_rd_s) begin
      case (host.addr)
        3'd0:    host.rdata <= {busy, hshift, cursor_on, blink_on, mode};
        3'd1:    host.rdata <= ptr_r[7:0];
        3'd2:    host.rdata <= {target_r, 1'b0, ptr_r[12:8]};
        3'd3:    host.rdata <= fill_val_r;
        3'd4:    host.rdata <= {1'b0, cursor_x};
        3'd5:    host.rdata <= {3'b000, cursor_y};
        3'd6:    host.rdata <= cursor_ch;
        3'd7:    host.rdata <= first_row;
        default: host.rdata <= 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_writer.sv
// Directed self-checking bench for vram_writer; fill scenarios are built when VRAM_WRITER_FILL_EN is defined.
module tb_vram_writer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy, swe, cwe, fwe, mode, blink_on, cursor_on;
  logic [12:0] saddr;
  logic [10:0] caddr;
  logic [11:0] faddr;
  logic [7:0]  swdata, cwdata, fwdata, cursor_ch, first_row;
  logic [3:0]  hshift;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  int pass_cnt = 0;
  int total_cnt = 0;

  vram_writer_if hif ();

  vram_writer dut (
    .clk(clk), .reset(reset), .host(hif.slave), .busy(busy),
    .saddr(saddr), .swdata(swdata), .swe(swe),
    .caddr(caddr), .cwdata(cwdata), .cwe(cwe),
    .faddr(faddr), .fwdata(fwdata), .fwe(fwe),
    .mode(mode), .blink_on(blink_on), .cursor_on(cursor_on), .hshift(hshift),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .cursor_ch(cursor_ch), .first_row(first_row)
  );

  always #5 clk = ~clk;

  task automatic host_write(input logic [2:0] a, input logic [7:0] d);
    hif.cs = 1'b1; hif.we = 1'b1; hif.addr = a; hif.wdata = d;
    @(posedge clk); #1;
    hif.cs = 1'b0; hif.we = 1'b0;
  endtask

  task automatic host_read(input logic [2:0] a, output logic [7:0] d);
    hif.cs = 1'b1; hif.we = 1'b0; hif.addr = a;
    @(posedge clk); #1;
    d = hif.rdata;
    hif.cs = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] rd;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({busy, swe, cwe, fwe} !== 4'h0) $display("FAIL reset_strobes: got %b expected 0000", {busy, swe, cwe, fwe});
    else pass_cnt++;
    total_cnt++;
    if ({saddr, swdata, caddr, cwdata, faddr, fwdata} !== 60'h0) $display("FAIL reset_ram_ports: got %h expected 0", {saddr, swdata, caddr, cwdata, faddr, fwdata});
    else pass_cnt++;
    total_cnt++;
    if ({mode, blink_on, cursor_on, hshift, cursor_x, cursor_y, cursor_ch, first_row} !== 35'h0)
      $display("FAIL reset_config: got %h expected 0", {mode, blink_on, cursor_on, hshift, cursor_x, cursor_y, cursor_ch, first_row});
    else pass_cnt++;
    reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      host_read(a[2:0], rd);
      total_cnt++;
      if (rd !== 8'h00 || {swe, cwe, fwe} !== 3'b000) $display("FAIL reset_read%0d: got %h/%b expected 00/000", a, rd, {swe, cwe, fwe});
      else pass_cnt++;
    end
  endtask

  task automatic test_screen_write;
    logic [7:0] rd;
    host_write(3'd2, 8'h00);
    host_write(3'd1, 8'h10);
    host_write(3'd3, 8'h41);
    total_cnt++;
    if ({swe, cwe, fwe, saddr, swdata} !== {3'b100, 13'h0010, 8'h41}) $display("FAIL screen_wr0: got %b %h %h expected 100 0010 41", {swe, cwe, fwe}, saddr, swdata);
    else pass_cnt++;
    host_write(3'd3, 8'h42);
    total_cnt++;
    if ({swe, cwe, fwe, saddr, swdata} !== {3'b100, 13'h0011, 8'h42}) $display("FAIL screen_wr1: got %b %h %h expected 100 0011 42", {swe, cwe, fwe}, saddr, swdata);
    else pass_cnt++;
    host_read(3'd1, rd);
    total_cnt++;
    if (swe !== 1'b0) $display("FAIL screen_pulse_width: got swe=%b expected 0", swe);
    else pass_cnt++;
    total_cnt++;
    if (rd !== 8'h12) $display("FAIL screen_ptr_lo: got %h expected 12", rd);
    else pass_cnt++;
  endtask

  task automatic test_colour_wrap;
    logic [7:0] rd;
    host_write(3'd2, 8'h47);
    host_write(3'd1, 8'hFF);
    host_write(3'd3, 8'h1E);
    total_cnt++;
    if ({swe, cwe, fwe, caddr, cwdata} !== {3'b010, 11'h7FF, 8'h1E}) $display("FAIL colour_wr0: got %b %h %h expected 010 7ff 1e", {swe, cwe, fwe}, caddr, cwdata);
    else pass_cnt++;
    host_write(3'd3, 8'h1E);
    total_cnt++;
    if ({swe, cwe, fwe, caddr, cwdata} !== {3'b010, 11'h000, 8'h1E}) $display("FAIL colour_wrap: got %b %h %h expected 010 000 1e", {swe, cwe, fwe}, caddr, cwdata);
    else pass_cnt++;
    host_read(3'd2, rd);
    total_cnt++;
    if (rd !== 8'h40) $display("FAIL colour_ptr_hi: got %h expected 40", rd);
    else pass_cnt++;
  endtask

  task automatic test_target_none;
    logic [7:0] rd;
    host_write(3'd2, 8'hC0);
    host_write(3'd1, 8'h05);
    host_write(3'd3, 8'h99);
    total_cnt++;
    if ({swe, cwe, fwe} !== 3'b000) $display("FAIL none_no_strobe: got %b expected 000", {swe, cwe, fwe});
    else pass_cnt++;
    host_read(3'd1, rd);
    total_cnt++;
    if (rd !== 8'h06) $display("FAIL none_ptr_inc: got %h expected 06", rd);
    else pass_cnt++;
  endtask

  task automatic test_config;
    logic [7:0] rd;
    host_write(3'd0, 8'h7E);
    total_cnt++;
    if ({hshift, cursor_on, blink_on, mode} !== 7'b1111110) $display("FAIL ctrl_outputs: got %b expected 1111110", {hshift, cursor_on, blink_on, mode});
    else pass_cnt++;
    host_read(3'd0, rd);
    total_cnt++;
    if (rd !== 8'h7E) $display("FAIL ctrl_read: got %h expected 7e", rd);
    else pass_cnt++;
    host_write(3'd4, 8'hFF);
    host_write(3'd5, 8'hFF);
    host_write(3'd7, 8'h18);
    total_cnt++;
    if ({cursor_x, cursor_y, first_row} !== {7'h7F, 5'h1F, 8'h18}) $display("FAIL cursor_outputs: got %h %h %h expected 7f 1f 18", cursor_x, cursor_y, first_row);
    else pass_cnt++;
    host_read(3'd4, rd);
    total_cnt++;
    if (rd !== 8'h7F) $display("FAIL cursor_x_read: got %h expected 7f", rd);
    else pass_cnt++;
    host_read(3'd5, rd);
    total_cnt++;
    if (rd !== 8'h1F) $display("FAIL cursor_y_read: got %h expected 1f", rd);
    else pass_cnt++;
    host_read(3'd7, rd);
    total_cnt++;
    if (rd !== 8'h18) $display("FAIL first_row_read: got %h expected 18", rd);
    else pass_cnt++;
  endtask

`ifdef VRAM_WRITER_FILL_EN
  task automatic test_fill_screen_end;
    logic [5:0]  exp_busy;
    logic [5:0]  exp_swe;
    logic [12:0] exp_addr;
    logic [7:0]  rd;
    exp_busy = 6'b001111;
    exp_swe  = 6'b001110;
    exp_addr = 13'h1FFD;
    host_write(3'd2, 8'h1F);
    host_write(3'd1, 8'hFC);
    host_write(3'd3, 8'h20);
    host_write(3'd0, 8'h81);
    total_cnt++;
    if (mode !== 1'b1) $display("FAIL fill_mode: got %b expected 1", mode);
    else pass_cnt++;
    for (int k = 0; k < 6; k++) begin
      total_cnt++;
      if (busy !== exp_busy[k] || swe !== exp_swe[k]) $display("FAIL fill_cycle%0d: got busy=%b swe=%b expected %b %b", k, busy, swe, exp_busy[k], exp_swe[k]);
      else pass_cnt++;
      if (exp_swe[k]) begin
        total_cnt++;
        if (saddr !== exp_addr || swdata !== 8'h20) $display("FAIL fill_addr%0d: got %h %h expected %h 20", k, saddr, swdata, exp_addr);
        else pass_cnt++;
        exp_addr = exp_addr + 13'h0001;
      end
      if (k == 0) begin
        hif.cs = 1'b1; hif.we = 1'b1; hif.addr = 3'd3; hif.wdata = 8'h55;
      end else begin
        hif.cs = 1'b0; hif.we = 1'b0;
      end
      @(posedge clk); #1;
    end
    host_read(3'd1, rd);
    total_cnt++;
    if (rd !== 8'h00) $display("FAIL fill_ptr_wrap: got %h expected 00", rd);
    else pass_cnt++;
    host_read(3'd3, rd);
    total_cnt++;
    if (rd !== 8'h20) $display("FAIL fill_value_kept: got %h expected 20", rd);
    else pass_cnt++;
  endtask

  task automatic test_fill_single;
    int nwr;
    logic [7:0] rd;
    nwr = 0;
    host_write(3'd2, 8'h47);
    host_write(3'd1, 8'hFF);
    host_write(3'd0, 8'h80);
    for (int k = 0; k < 6; k++) begin
      if (cwe === 1'b1) begin
        nwr++;
        total_cnt++;
        if (caddr !== 11'h7FF || cwdata !== 8'h20) $display("FAIL single_addr: got %h %h expected 7ff 20", caddr, cwdata);
        else pass_cnt++;
      end
      @(posedge clk); #1;
    end
    total_cnt++;
    if (nwr !== 1 || busy !== 1'b0) $display("FAIL single_count: got %0d busy=%b expected 1 0", nwr, busy);
    else pass_cnt++;
    host_read(3'd2, rd);
    total_cnt++;
    if (rd !== 8'h40) $display("FAIL single_ptr_hi: got %h expected 40", rd);
    else pass_cnt++;
  endtask

  task automatic test_fill_reset;
    int nwr;
    logic [7:0] rd;
    nwr = 0;
    host_write(3'd3, 8'h3C);
    host_write(3'd2, 8'h80);
    host_write(3'd1, 8'h00);
    host_write(3'd0, 8'h80);
    for (int k = 0; k < 20 && nwr < 10; k++) begin
      @(posedge clk); #1;
      if (fwe === 1'b1) begin
        total_cnt++;
        if (faddr !== nwr[11:0] || fwdata !== 8'h3C || {swe, cwe} !== 2'b00) $display("FAIL font_fill%0d: got %h %h %b expected %h 3c 00", nwr, faddr, fwdata, {swe, cwe}, nwr[11:0]);
        else pass_cnt++;
        nwr++;
      end
    end
    total_cnt++;
    if (nwr !== 10) $display("FAIL font_fill_timeout: got %0d writes expected 10", nwr);
    else pass_cnt++;
    reset = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if ({busy, fwe, swe, cwe} !== 4'h0) $display("FAIL reset_abort: got %b expected 0000", {busy, fwe, swe, cwe});
    else pass_cnt++;
    reset = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if ({busy, fwe} !== 2'b00) $display("FAIL reset_abort_hold: got %b expected 00", {busy, fwe});
    else pass_cnt++;
    for (int a = 0; a < 8; a++) begin
      host_read(a[2:0], rd);
      total_cnt++;
      if (rd !== 8'h00) $display("FAIL abort_read%0d: got %h expected 00", a, rd);
      else pass_cnt++;
    end
  endtask
`else
  task automatic test_no_fill;
    logic [7:0] rd;
    host_write(3'd2, 8'h00);
    host_write(3'd1, 8'h00);
    host_write(3'd0, 8'h85);
    total_cnt++;
    if ({busy, mode, cursor_on} !== 3'b011) $display("FAIL nofill_ctrl: got %b expected 011", {busy, mode, cursor_on});
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if ({busy, swe} !== 2'b00) $display("FAIL nofill_idle: got %b expected 00", {busy, swe});
    else pass_cnt++;
    host_read(3'd0, rd);
    total_cnt++;
    if (rd !== 8'h05) $display("FAIL nofill_read: got %h expected 05", rd);
    else pass_cnt++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    hif.cs = 1'b0; hif.we = 1'b0; hif.addr = 3'd0; hif.wdata = 8'h00;
    test_reset();
    test_screen_write();
    test_colour_wrap();
    test_target_none();
    test_config();
`ifdef VRAM_WRITER_FILL_EN
    test_fill_screen_end();
    test_fill_single();
    test_fill_reset();
`else
    test_no_fill();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
